// File: rtl/decode_stage_if.sv
// Bus bundle for the decode stage: fetch-side handshake, execute-side
// handshake with decoded fields, writeback release, flush and status.
interface decode_stage_if #(
   parameter int IW  = 32,
   parameter int OPW = 4,
   parameter int AW  = 5,
   parameter int NW  = 8,
   parameter int CW  = 16
);
   logic           in_valid;
   logic           in_ready;
   logic [IW-1:0]  in_instr;
   logic           out_valid;
   logic           out_ready;
   logic [OPW-1:0] out_opcode;
   logic [AW-1:0]  out_addr1;
   logic [AW-1:0]  out_addr2;
   logic [AW-1:0]  out_addr3;
   logic [NW-1:0]  out_number;
   logic           out_wr;
   logic           wb_valid;
   logic [AW-1:0]  wb_addr;
   logic           flush;
   logic [CW-1:0]  stall_cnt;
   logic           busy;

   // The decode stage itself
   modport slave (
      input  in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
      output in_ready, out_valid, out_opcode, out_addr1, out_addr2,
             out_addr3, out_number, out_wr, stall_cnt, busy
   );

   // Whatever surrounds the stage (fetch, execute, writeback)
   modport master (
      output in_valid, in_instr, out_ready, wb_valid, wb_addr, flush,
      input  in_ready, out_valid, out_opcode, out_addr1, out_addr2,
             out_addr3, out_number, out_wr, stall_cnt, busy
   );
endinterface

// File: rtl/decode_stage.sv
// Registered, handshaked instruction decode stage. Splits the instruction
// into opcode / addr1 / addr2 / addr3 / number, tracks pending register
// writes in a scoreboard and stalls fetch on read-after-write hazards.
module decode_stage #(
   parameter int                IW        = 32,
   parameter int                OPW       = 4,
   parameter int                AW        = 5,
   parameter int                NW        = 8,
   parameter logic [2**OPW-1:0] NOWR_MASK = '0,
   parameter logic [2**OPW-1:0] IMM_MASK  = '0,
   parameter int                CW        = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   decode_stage_if.slave bus
);

   localparam int            NREG      = 2**AW;
   localparam logic [CW-1:0] STALL_MAX = '1;

   // The fields must fit side by side inside the instruction word
   generate
      if (OPW + 3*AW + NW > IW) begin : g_badFieldLayout
         $error("decode_stage: OPW+3*AW+NW exceeds IW");
      end
   endgenerate

   logic [OPW-1:0]  w_opcode;
   logic [AW-1:0]   w_addr1;
   logic [AW-1:0]   w_addr2;
   logic [AW-1:0]   w_addr3;
   logic [NW-1:0]   w_number;
   logic            w_writes;
   logic [NREG-1:0] w_sbView;
   logic            w_hazard;
   logic            w_inReady;
   logic            w_accept;
   logic [NREG-1:0] w_sbNext;

   logic            r_outValid;
   logic [OPW-1:0]  r_opcode;
   logic [AW-1:0]   r_addr1;
   logic [AW-1:0]   r_addr2;
   logic [AW-1:0]   r_addr3;
   logic [NW-1:0]   r_number;
   logic            r_wr;
   logic [NREG-1:0] r_sb;
   logic [CW-1:0]   r_stallCnt;

   assign w_opcode = bus.in_instr[IW-1 -: OPW];
   assign w_addr1  = bus.in_instr[IW-OPW-1 -: AW];
   assign w_addr2  = bus.in_instr[IW-OPW-AW-1 -: AW];
   assign w_addr3  = bus.in_instr[IW-OPW-2*AW-1 -: AW];
   assign w_number = bus.in_instr[NW-1:0];

   // Register 0 is hardwired, so a write to it is never tracked
   assign w_writes = ~NOWR_MASK[w_opcode] & (w_addr1 != '0);

   // Register 0 can never be pending, whatever the scoreboard holds
   assign w_sbView = {r_sb[NREG-1:1], 1'b0};

   // Hazard uses the registered scoreboard only, so a writeback arriving
   // this cycle releases the stall no earlier than the next cycle
   assign w_hazard = bus.in_valid &
                     (w_sbView[w_addr2] | (w_sbView[w_addr3] & ~IMM_MASK[w_opcode]));

   assign w_inReady = ~w_hazard & (~r_outValid | bus.out_ready) & ~bus.flush;
   assign w_accept  = bus.in_valid & w_inReady;

   // Next scoreboard: writeback clears first, then a new writer sets, so a
   // same-address set wins; flush wipes everything including writeback
   always_comb begin
      w_sbNext = r_sb;
      if (bus.flush) begin
         w_sbNext = '0;
      end else begin
         if (bus.wb_valid) begin
            w_sbNext[bus.wb_addr] = 1'b0;
         end
         if (w_accept && w_writes) begin
            w_sbNext[w_addr1] = 1'b1;
         end
      end
   end

   // Output register: load on accept, drop valid when consumed, otherwise
   // hold every field stable while execute is applying backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outValid <= 1'b0;
         r_opcode   <= '0;
         r_addr1    <= '0;
         r_addr2    <= '0;
         r_addr3    <= '0;
         r_number   <= '0;
         r_wr       <= 1'b0;
      end else if (bus.flush) begin
         r_outValid <= 1'b0;
      end else if (w_accept) begin
         r_outValid <= 1'b1;
         r_opcode   <= w_opcode;
         r_addr1    <= w_addr1;
         r_addr2    <= w_addr2;
         r_addr3    <= w_addr3;
         r_number   <= w_number;
         r_wr       <= w_writes;
      end else if (bus.out_ready) begin
         r_outValid <= 1'b0;
      end
   end

   // Scoreboard of registers with a write still in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sb <= '0;
      end else begin
         r_sb <= w_sbNext;
      end
   end

   // Saturating count of cycles spent stalled on a hazard; flush does not
   // reset it so it survives pipeline recovery
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
      end else if (w_hazard && !bus.flush && r_stallCnt != STALL_MAX) begin
         r_stallCnt <= r_stallCnt + CW'(1);
      end
   end

   assign bus.in_ready   = w_inReady;
   assign bus.out_valid  = r_outValid;
   assign bus.out_opcode = r_opcode;
   assign bus.out_addr1  = r_addr1;
   assign bus.out_addr2  = r_addr2;
   assign bus.out_addr3  = r_addr3;
   assign bus.out_number = r_number;
   assign bus.out_wr     = r_wr;
   assign bus.stall_cnt  = r_stallCnt;
   assign bus.busy       = |r_sb;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a decode vector table, hand-written
// multi-cycle corner cases and a randomized run against a reference model.
module tb_decode_stage;

   localparam int IW = 32;
   localparam int OPW = 4;
   localparam int AW = 5;
   localparam int NW = 8;
   localparam int CW = 4;
   // Opcode 15 never writes addr1, opcode 14 uses the immediate instead of addr3
   localparam logic [15:0] NOWR_MASK = 16'h8000;
   localparam logic [15:0] IMM_MASK  = 16'h4000;
   localparam int STALL_SAT = 15;

   logic clk;
   logic rst_n;
   int   totalChecks;
   int   badChecks;

   decode_stage_if #(.IW(IW), .OPW(OPW), .AW(AW), .NW(NW), .CW(CW)) bus ();

   decode_stage #(
      .IW(IW), .OPW(OPW), .AW(AW), .NW(NW),
      .NOWR_MASK(NOWR_MASK), .IMM_MASK(IMM_MASK), .CW(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave)
   );

   // Free-running 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  op;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  a3;
      logic [7:0]  num;
      logic        wr;
   } vec_t;

   vec_t vecs[6];

   // Reference model state
   bit          mPend[32];
   bit          mValid;
   logic [31:0] mInstr;
   int          mStall;

   function automatic logic [31:0] mk(int op, int a1, int a2, int a3, int num);
      return (op << 28) | (a1 << 23) | (a2 << 18) | (a3 << 13) | num;
   endfunction

   function automatic int fld(logic [31:0] w, int lsb, int width);
      return int'((w >> lsb) & ((32'd1 << width) - 1));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic ordy,
                                input logic wbv, input logic [4:0] wba, input logic fl);
      @(negedge clk);
      bus.in_valid  = iv;
      bus.in_instr  = instr;
      bus.out_ready = ordy;
      bus.wb_valid  = wbv;
      bus.wb_addr   = wba;
      bus.flush     = fl;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
      bus.wb_valid = 1'b0; bus.wb_addr = '0;  bus.flush = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic bit modelHazard(logic [31:0] w);
      int op = fld(w, 28, 4);
      int a2 = fld(w, 18, 5);
      int a3 = fld(w, 13, 5);
      bit readsA3 = (op != 14);
      return (a2 != 0 && mPend[a2]) || (readsA3 && a3 != 0 && mPend[a3]);
   endfunction

   function automatic bit modelWrites(logic [31:0] w);
      return (fld(w, 28, 4) != 15) && (fld(w, 23, 5) != 0);
   endfunction

   function automatic bit modelBusy();
      bit any = 0;
      for (int k = 0; k < 32; k++) any |= mPend[k];
      return any;
   endfunction

   // Main test sequence
   initial begin
      logic [31:0] reader;
      logic [31:0] first;
      logic [31:0] second;
      logic [31:0] rInstr;
      bit          rValid;
      bit          rOrdy;
      bit          rWb;
      bit          rFlush;
      logic [4:0]  rWbAddr;
      bit          expReady;
      bit          acc;
      bit          haz;
      bit          wasAccepted;

      clk = 1'b0;
      rst_n = 1'b0;
      totalChecks = 0;
      badChecks = 0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
      bus.wb_valid = 1'b0; bus.wb_addr = '0;  bus.flush = 1'b0;

      vecs[0] = '{32'h1A4C_8E05, 4'h1, 5'h14, 5'h13, 5'h04, 8'h05, 1'b1};
      vecs[1] = '{32'h0000_00FF, 4'h0, 5'h00, 5'h00, 5'h00, 8'hFF, 1'b0};
      vecs[2] = '{32'hF800_0000, 4'hF, 5'h10, 5'h00, 5'h00, 8'h00, 1'b0};
      vecs[3] = '{32'h7FFF_FFFF, 4'h7, 5'h1F, 5'h1F, 5'h1F, 8'hFF, 1'b1};
      vecs[4] = '{32'hE000_2A33, 4'hE, 5'h00, 5'h00, 5'h01, 8'h33, 1'b0};
      vecs[5] = '{32'h2088_2101, 4'h2, 5'h01, 5'h02, 5'h01, 8'h01, 1'b1};

      applyReset();
      #1;
      checkOutput("rst_valid", bus.out_valid, 0);
      checkOutput("rst_opcode", bus.out_opcode, 0);
      checkOutput("rst_addr1", bus.out_addr1, 0);
      checkOutput("rst_number", bus.out_number, 0);
      checkOutput("rst_stall", bus.stall_cnt, 0);
      checkOutput("rst_busy", bus.busy, 0);

      $display("[TB] decode vector table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, '0, 1, 0, 0, 1);
         cycle();
         applyStimulus(1, vecs[i].instr, 1, 0, 0, 0);
         #1;
         checkOutput("vec_ready", bus.in_ready, 1);
         cycle();
         checkOutput("vec_valid", bus.out_valid, 1);
         checkOutput("vec_opcode", bus.out_opcode, vecs[i].op);
         checkOutput("vec_addr1", bus.out_addr1, vecs[i].a1);
         checkOutput("vec_addr2", bus.out_addr2, vecs[i].a2);
         checkOutput("vec_addr3", bus.out_addr3, vecs[i].a3);
         checkOutput("vec_number", bus.out_number, vecs[i].num);
         checkOutput("vec_wr", bus.out_wr, vecs[i].wr);
         checkOutput("vec_busy", bus.busy, vecs[i].wr);
      end

      $display("[TB] RAW stall");
      applyReset();
      applyStimulus(1, mk(1, 3, 0, 0, 0), 1, 0, 0, 0);
      #1;
      checkOutput("raw_wr_ready", bus.in_ready, 1);
      cycle();
      checkOutput("raw_busy", bus.busy, 1);
      reader = mk(1, 5, 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, reader, 1, 0, 0, 0);
         #1;
         checkOutput("raw_stall_ready", bus.in_ready, 0);
         cycle();
         checkOutput("raw_stall_cnt", bus.stall_cnt, i + 1);
      end
      applyStimulus(1, reader, 1, 1, 3, 0);
      #1;
      checkOutput("raw_wb_ready", bus.in_ready, 0);
      cycle();
      checkOutput("raw_wb_cnt", bus.stall_cnt, 4);
      applyStimulus(1, reader, 1, 0, 0, 0);
      #1;
      checkOutput("raw_release_ready", bus.in_ready, 1);
      cycle();
      checkOutput("raw_out_valid", bus.out_valid, 1);
      checkOutput("raw_out_addr2", bus.out_addr2, 3);
      checkOutput("raw_out_addr1", bus.out_addr1, 5);
      checkOutput("raw_final_cnt", bus.stall_cnt, 4);

      $display("[TB] backpressure");
      applyReset();
      first  = mk(2, 6, 1, 2, 8'hAA);
      second = mk(3, 7, 0, 0, 8'h55);
      applyStimulus(1, first, 0, 0, 0, 0);
      #1;
      checkOutput("bp_first_ready", bus.in_ready, 1);
      cycle();
      checkOutput("bp_first_valid", bus.out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, second, 0, 0, 0, 0);
         #1;
         checkOutput("bp_hold_ready", bus.in_ready, 0);
         cycle();
         checkOutput("bp_hold_valid", bus.out_valid, 1);
         checkOutput("bp_hold_addr1", bus.out_addr1, 6);
         checkOutput("bp_hold_number", bus.out_number, 8'hAA);
      end
      applyStimulus(1, second, 1, 0, 0, 0);
      #1;
      checkOutput("bp_release_ready", bus.in_ready, 1);
      cycle();
      checkOutput("bp_second_valid", bus.out_valid, 1);
      checkOutput("bp_second_addr1", bus.out_addr1, 7);
      checkOutput("bp_second_number", bus.out_number, 8'h55);
      applyStimulus(0, '0, 1, 0, 0, 0);
      cycle();
      checkOutput("bp_drain_valid", bus.out_valid, 0);

      $display("[TB] simultaneous set and clear");
      applyReset();
      applyStimulus(1, mk(1, 7, 0, 0, 0), 1, 0, 0, 0);
      cycle();
      applyStimulus(1, mk(4, 7, 0, 0, 0), 1, 1, 7, 0);
      #1;
      checkOutput("sc_ready", bus.in_ready, 1);
      cycle();
      checkOutput("sc_busy", bus.busy, 1);
      applyStimulus(1, mk(1, 2, 7, 0, 0), 1, 0, 0, 0);
      #1;
      checkOutput("sc_r7_still_pending", bus.in_ready, 0);
      applyStimulus(1, mk(1, 0, 0, 7, 0), 1, 0, 0, 0);
      #1;
      checkOutput("sc_addr3_hazard", bus.in_ready, 0);
      applyStimulus(1, mk(14, 0, 0, 7, 0), 1, 0, 0, 0);
      #1;
      checkOutput("sc_imm_no_hazard", bus.in_ready, 1);
      applyStimulus(1, mk(1, 0, 0, 0, 0), 1, 0, 0, 0);
      #1;
      checkOutput("sc_r0_no_hazard", bus.in_ready, 1);

      $display("[TB] flush");
      applyStimulus(1, mk(1, 9, 0, 0, 0), 0, 0, 0, 0);
      cycle();
      checkOutput("fl_pre_valid", bus.out_valid, 1);
      checkOutput("fl_pre_busy", bus.busy, 1);
      applyStimulus(1, mk(1, 10, 0, 0, 0), 0, 1, 7, 1);
      #1;
      checkOutput("fl_ready", bus.in_ready, 0);
      cycle();
      checkOutput("fl_busy", bus.busy, 0);
      checkOutput("fl_valid", bus.out_valid, 0);

      $display("[TB] stall saturation");
      applyReset();
      applyStimulus(1, mk(1, 9, 0, 0, 0), 1, 0, 0, 0);
      cycle();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, mk(1, 1, 9, 0, 0), 1, 0, 0, 0);
         cycle();
         if (i == 14) checkOutput("sat_reach", bus.stall_cnt, 15);
      end
      checkOutput("sat_final", bus.stall_cnt, 15);

      $display("[TB] asynchronous reset mid-transfer");
      applyStimulus(0, '0, 1, 0, 0, 0);
      cycle();
      applyStimulus(1, mk(3, 4, 0, 0, 8'h77), 0, 0, 0, 0);
      cycle();
      checkOutput("ar_pre_valid", bus.out_valid, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar_valid", bus.out_valid, 0);
      checkOutput("ar_opcode", bus.out_opcode, 0);
      checkOutput("ar_addr1", bus.out_addr1, 0);
      checkOutput("ar_number", bus.out_number, 0);
      checkOutput("ar_stall", bus.stall_cnt, 0);
      checkOutput("ar_busy", bus.busy, 0);

      $display("[TB] randomized run against reference model");
      applyReset();
      for (int k = 0; k < 32; k++) mPend[k] = 0;
      mValid = 0;
      mInstr = '0;
      mStall = 0;
      rValid = 0;
      rInstr = '0;
      wasAccepted = 1;
      for (int n = 0; n < 600; n++) begin
         // Upstream keeps a refused instruction stable until it is taken
         if (!(rValid && !wasAccepted)) begin
            rValid = ($urandom_range(0, 3) != 0);
            rInstr = mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 255));
         end
         rOrdy   = ($urandom_range(0, 9) < 7);
         rWb     = ($urandom_range(0, 2) == 0);
         rWbAddr = 5'($urandom_range(0, 3));
         rFlush  = ($urandom_range(0, 24) == 0);
         applyStimulus(rValid, rInstr, rOrdy, rWb, rWbAddr, rFlush);

         haz      = rValid && modelHazard(rInstr);
         expReady = !haz && (!mValid || rOrdy) && !rFlush;
         acc      = rValid && expReady;
         #1;
         checkOutput("rnd_in_ready", bus.in_ready, expReady);

         if (rFlush) begin
            for (int k = 0; k < 32; k++) mPend[k] = 0;
            mValid = 0;
         end else begin
            if (rWb) mPend[rWbAddr] = 0;
            if (acc && modelWrites(rInstr)) mPend[fld(rInstr, 23, 5)] = 1;
            if (acc) begin
               mValid = 1;
               mInstr = rInstr;
            end else if (rOrdy) begin
               mValid = 0;
            end
         end
         if (haz && !rFlush && mStall < STALL_SAT) mStall++;
         wasAccepted = acc;

         cycle();
         checkOutput("rnd_out_valid", bus.out_valid, mValid);
         checkOutput("rnd_busy", bus.busy, modelBusy());
         checkOutput("rnd_stall_cnt", bus.stall_cnt, mStall);
         if (mValid) begin
            checkOutput("rnd_opcode", bus.out_opcode, fld(mInstr, 28, 4));
            checkOutput("rnd_addr1", bus.out_addr1, fld(mInstr, 23, 5));
            checkOutput("rnd_addr2", bus.out_addr2, fld(mInstr, 18, 5));
            checkOutput("rnd_addr3", bus.out_addr3, fld(mInstr, 13, 5));
            checkOutput("rnd_number", bus.out_number, fld(mInstr, 0, 8));
            checkOutput("rnd_wr", bus.out_wr, modelWrites(mInstr));
         end
      end

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction decode stage; successor to the combinational control unit.
- Splits an IW-bit instruction into the following fields:
  - opcode
  - destination address (addr1)
  - two source addresses (addr2, addr3)
  - immediate (number)
- Tracks pending register writes in a scoreboard and stalls on read-after-write hazards.
- Sits between fetch (upstream valid/ready) and execute (downstream valid/ready); writeback clears scoreboard bits.

Parameters:
- IW, 32, instruction width.
- OPW, 4, opcode width; field at instr[IW-1 -: OPW].
- AW, 5, register address width; addr1 at next AW bits below opcode, then addr2, then addr3.
- NW, 8, immediate width; field at instr[NW-1:0]. Elaboration error unless OPW+3*AW+NW <= IW.
- NOWR_MASK, 16'h0000, bit k=1 means opcode k does not write addr1.
- IMM_MASK, 16'h0000, bit k=1 means opcode k does not read addr3 (uses number instead).
- CW, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction available.
- in_ready  output  1  stage accepts instruction this cycle.
- in_instr  input  IW  instruction word.
- out_valid  output  1  decoded fields valid.
- out_ready  input  1  execute accepts decoded fields.
- out_opcode  output  OPW  decoded opcode.
- out_addr1  output  AW  destination address.
- out_addr2  output  AW  source address 1.
- out_addr3  output  AW  source address 2.
- out_number  output  NW  immediate.
- out_wr  output  1  instruction writes addr1 (NOWR_MASK bit clear and addr1 != 0).
- wb_valid  input  1  writeback completes.
- wb_addr  input  AW  register written back.
- flush  input  1  synchronous pipeline flush.
- stall_cnt  output  CW  saturating count of hazard-stall cycles.
- busy  output  1  any scoreboard bit set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0; all out_* fields=0.
  - Scoreboard (2^AW bits) cleared; stall_cnt=0; busy=0.
- Decode is combinational on in_instr; all out_* fields are registered. Latency is 1 cycle from accept to out_valid.
- hazard = in_valid & (sb[addr2] | (sb[addr3] & ~IMM_MASK[opcode])), using the registered scoreboard.
  - Register 0 is never pending: sb[0] is forced 0.
- in_ready = ~hazard & (~out_valid | out_ready) & ~flush.
- Accept occurs when in_valid & in_ready.
- Output register on each clock edge:
  - On accept: load fields and set out_valid=1.
  - Else if out_ready: out_valid=0.
  - Else: hold all outputs stable (no field change while out_valid & ~out_ready).
- Scoreboard per clock edge:
  - Clear sb[wb_addr] if wb_valid.
  - Then set sb[in addr1] if accept & out_wr-condition.
  - Set wins over clear for the same address in the same cycle.
- Writeback in the same cycle as a hazard check does not release the stall that cycle; the instruction is accepted the next cycle at earliest.
- flush (synchronous, highest priority below reset):
  - out_valid=0, scoreboard cleared, no accept that cycle.
  - wb_valid that cycle is ignored.
  - stall_cnt is not cleared.
- stall_cnt increments each cycle with in_valid & hazard & ~flush; it saturates at 2^CW-1 and does not wrap.
- busy = |sb, registered view.
- No state machine beyond valid register and scoreboard. Upstream must hold in_instr stable while in_valid & ~in_ready.

Test Plan:
- Reset mid-transfer: out_valid=1 holding instr, assert rst_n=0 asynchronously.
  - Response: out_valid, fields, stall_cnt, busy drop to 0 before the next edge.
- Single decode: instr=32'h1A4C_8E05 with default params, in_valid=1, out_ready=1.
  - Next cycle: out_valid=1, opcode=4'h1, addr1=5'h14, addr2=5'h13, addr3=5'h04, number=8'h05, out_wr=1, sb[20]=1.
- RAW stall:
  - Issue write to r3, then an instruction reading r3 as addr2. in_ready=0 and stall_cnt increments each cycle.
  - Pulse wb_valid, wb_addr=3 at cycle N: accept at N+1, stall_cnt=final count.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1.
  - Outputs stable, in_ready=0; release gives exactly one handoff, no duplicate or loss.
- Simultaneous set/clear: accept instr writing r7 while wb_valid wb_addr=7 → sb[7]=1 afterwards. Reading r0 never stalls.
- Flush and saturation:
  - flush with sb nonzero → busy=0 next cycle, out_valid=0.
  - CW=4 bench, 20 stall cycles → stall_cnt=15.
